// File: rtl/fetch_if.sv
`timescale 1ns/1ps
// Fetch-stage signal bundle: instruction-memory port, execute-stage redirect inputs, decode-stage outputs.
interface fetch_if;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic [1:0]  ex_jump;
  logic [1:0]  ex_branch_inst;
  logic        ex_alu_zero;
  logic [31:0] ex_pc_plus4;
  logic [31:0] ex_imm;
  logic [25:0] ex_instr_index;
  logic [31:0] ex_rs_data;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [5:0]  id_func;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        redirect;

  modport master (
    output imem_addr, imem_en, id_valid, id_instr, id_opcode, id_func, id_pc, id_pc_plus4, redirect,
    input  imem_rdata, id_stall, ex_jump, ex_branch_inst, ex_alu_zero, ex_pc_plus4, ex_imm,
           ex_instr_index, ex_rs_data
  );

  modport slave (
    input  imem_addr, imem_en, id_valid, id_instr, id_opcode, id_func, id_pc, id_pc_plus4, redirect,
    output imem_rdata, id_stall, ex_jump, ex_branch_inst, ex_alu_zero, ex_pc_plus4, ex_imm,
           ex_instr_index, ex_rs_data
  );
endinterface

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch: PC owner, one outstanding imem read, one-entry skid behind id_stall.
// Two cycles from reset or redirect-load to id_valid; id_stall freezes id_* and blocks new reads.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master fif
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        taken;
  logic [31:0] target;

  always_comb begin
    taken = (fif.ex_jump == 2'b01) || (fif.ex_jump == 2'b10) ||
            ((fif.ex_branch_inst == 2'b01) && fif.ex_alu_zero) ||
            ((fif.ex_branch_inst == 2'b10) && !fif.ex_alu_zero);
    // Jump encodings outrank the branch encoding when both are present.
    if (fif.ex_jump == 2'b01) begin
      target = {fif.ex_pc_plus4[31:28], fif.ex_instr_index, 2'b00};
    end else if (fif.ex_jump == 2'b10) begin
      target = fif.ex_rs_data;
    end else begin
      target = fif.ex_pc_plus4 + (fif.ex_imm << 2);
    end
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    skid_vld_d    = skid_vld_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;

    if (taken) begin
      pc_d       = target;
      inflight_d = 1'b0;
      skid_vld_d = 1'b0;
      id_valid_d = 1'b0;
    end else if (!fif.id_stall) begin
      pc_d          = pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      if (skid_vld_q) begin
        id_valid_d    = 1'b1;
        id_instr_d    = skid_instr_q;
        id_pc_d       = skid_pc_q;
        id_pc_plus4_d = skid_pc_q + 32'd4;
        skid_vld_d    = inflight_q;
        skid_instr_d  = fif.imem_rdata;
        skid_pc_d     = inflight_pc_q;
      end else begin
        id_valid_d = inflight_q;
        if (inflight_q) begin
          id_instr_d    = fif.imem_rdata;
          id_pc_d       = inflight_pc_q;
          id_pc_plus4_d = inflight_pc_q + 32'd4;
        end
      end
    end else begin
      // Stalled: park the returning read so it is not lost.
      inflight_d = 1'b0;
      if (inflight_q && !skid_vld_q) begin
        skid_vld_d   = 1'b1;
        skid_instr_d = fif.imem_rdata;
        skid_pc_d    = inflight_pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      skid_vld_q    <= 1'b0;
      skid_instr_q  <= 32'd0;
      skid_pc_q     <= 32'd0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= 32'd0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_vld_q    <= skid_vld_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  assign fif.imem_addr   = pc_q;
  assign fif.imem_en     = !fif.id_stall && !rst;
  assign fif.redirect    = taken;
  assign fif.id_valid    = id_valid_q;
  assign fif.id_instr    = id_instr_q;
  assign fif.id_opcode   = id_instr_q[31:26];
  assign fif.id_func     = id_instr_q[5:0];
  assign fif.id_pc       = id_pc_q;
  assign fif.id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Bench for fetch_unit: redirect vector table plus reset/stall/redirect sequences, with an in-order delivery scoreboard.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  typedef struct {
    logic [1:0]  jump;
    logic [1:0]  br;
    logic        zero;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic        exp_redir;
    logic [31:0] exp_addr;
  } vec_t;

  localparam int NV = 13;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  sb_t  sb_q[$];
  sb_t  exp_e;
  logic stall_at_edge = 1'b0;
  vec_t vecs[NV];

  fetch_if fif();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h0C00_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (fif.imem_en) fif.imem_rdata <= imem_word(fif.imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) stall_at_edge = fif.id_stall;

  // Every unstalled edge that leaves id_valid high is a new delivery.
  always @(negedge clk) begin
    if (!rst && !stall_at_edge && fif.id_valid && sb_q.size() > 0) begin
      exp_e = sb_q.pop_front();
      chk("id_pc", fif.id_pc, exp_e.pc);
      chk("id_instr", fif.id_instr, exp_e.instr);
      chk("id_pc_plus4", fif.id_pc_plus4, exp_e.pc + 32'd4);
      chk("id_opcode", {26'd0, fif.id_opcode}, {26'd0, exp_e.instr[31:26]});
      chk("id_func", {26'd0, fif.id_func}, {26'd0, exp_e.instr[5:0]});
    end
  end

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      sb_t e;
      e.pc    = start + 32'(4 * k);
      e.instr = imem_word(e.pc);
      sb_q.push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_ex();
    fif.ex_jump        = 2'b00;
    fif.ex_branch_inst = 2'b00;
    fif.ex_alu_zero    = 1'b0;
    fif.ex_pc_plus4    = 32'd0;
    fif.ex_imm         = 32'd0;
    fif.ex_instr_index = 26'd0;
    fif.ex_rs_data     = 32'd0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    fif.id_stall = 1'b0;
    clear_ex();
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    for (int k = 0; k < max_cyc && sb_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
    $fatal(1);
  end

  initial begin
    //           jump   br     zero  pc4            imm            idx         rs             redir addr
    vecs[0]  = '{2'b00, 2'b01, 1'b1, 32'h0000_0040, 32'hFFFF_FFFC, 26'h0,      32'h0,         1'b1, 32'h0000_0030};
    vecs[1]  = '{2'b00, 2'b01, 1'b0, 32'h0000_0040, 32'hFFFF_FFFC, 26'h0,      32'h0,         1'b0, 32'h0000_0004};
    vecs[2]  = '{2'b00, 2'b10, 1'b0, 32'h0000_0040, 32'hFFFF_FFFC, 26'h0,      32'h0,         1'b1, 32'h0000_0030};
    vecs[3]  = '{2'b00, 2'b10, 1'b1, 32'h0000_0040, 32'hFFFF_FFFC, 26'h0,      32'h0,         1'b0, 32'h0000_0004};
    vecs[4]  = '{2'b01, 2'b00, 1'b0, 32'h1000_0004, 32'h0,         26'h10,     32'h0,         1'b1, 32'h1000_0040};
    vecs[5]  = '{2'b10, 2'b00, 1'b0, 32'h0,         32'h0,         26'h0,      32'h0000_0200, 1'b1, 32'h0000_0200};
    vecs[6]  = '{2'b01, 2'b01, 1'b1, 32'h1000_0004, 32'hFFFF_FFFC, 26'h10,     32'h0,         1'b1, 32'h1000_0040};
    vecs[7]  = '{2'b10, 2'b01, 1'b1, 32'h0000_0040, 32'hFFFF_FFFC, 26'h0,      32'h0000_0204, 1'b1, 32'h0000_0204};
    vecs[8]  = '{2'b11, 2'b11, 1'b1, 32'h0000_0040, 32'hFFFF_FFFC, 26'h10,     32'h0000_0200, 1'b0, 32'h0000_0004};
    vecs[9]  = '{2'b11, 2'b01, 1'b1, 32'h0000_0040, 32'hFFFF_FFFC, 26'h0,      32'h0000_0200, 1'b1, 32'h0000_0030};
    vecs[10] = '{2'b00, 2'b01, 1'b1, 32'hFFFF_FFFC, 32'h0000_0010, 26'h0,      32'h0,         1'b1, 32'h0000_003C};
    vecs[11] = '{2'b10, 2'b00, 1'b0, 32'h0,         32'h0,         26'h0,      32'h0000_0203, 1'b1, 32'h0000_0203};
    vecs[12] = '{2'b01, 2'b00, 1'b0, 32'hF000_0000, 32'h0,         26'h3FF_FFFF, 32'h0,       1'b1, 32'hFFFF_FFFC};

    // Reset state and first deliveries.
    rst          = 1'b1;
    fif.id_stall = 1'b0;
    clear_ex();
    cyc(1);
    chk("rst id_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("rst imem_addr", fif.imem_addr, 32'h0);
    chk("rst imem_en", {31'd0, fif.imem_en}, 32'd0);
    chk("rst redirect", {31'd0, fif.redirect}, 32'd0);
    cyc(1);
    rst = 1'b0;
    push_seq(32'h0, 4);
    #1;
    chk("start imem_en", {31'd0, fif.imem_en}, 32'd1);
    chk("start imem_addr", fif.imem_addr, 32'h0);
    cyc(1);
    chk("e1 imem_addr", fif.imem_addr, 32'h4);
    chk("e1 id_valid", {31'd0, fif.id_valid}, 32'd0);
    cyc(1);
    chk("e2 imem_addr", fif.imem_addr, 32'h8);
    chk("e2 id_valid", {31'd0, fif.id_valid}, 32'd1);
    wait_drain("startup drain", 10);

    // Redirect vector table, each applied in the first cycle after reset.
    for (int i = 0; i < NV; i++) begin
      do_reset();
      fif.ex_jump        = vecs[i].jump;
      fif.ex_branch_inst = vecs[i].br;
      fif.ex_alu_zero    = vecs[i].zero;
      fif.ex_pc_plus4    = vecs[i].pc4;
      fif.ex_imm         = vecs[i].imm;
      fif.ex_instr_index = vecs[i].idx;
      fif.ex_rs_data     = vecs[i].rs;
      push_seq(vecs[i].exp_redir ? vecs[i].exp_addr : 32'h0, 2);
      #1;
      chk($sformatf("vec%0d redirect", i), {31'd0, fif.redirect}, {31'd0, vecs[i].exp_redir});
      cyc(1);
      clear_ex();
      chk($sformatf("vec%0d imem_addr", i), fif.imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d id_valid e1", i), {31'd0, fif.id_valid}, 32'd0);
      if (vecs[i].exp_redir) begin
        cyc(1);
        chk($sformatf("vec%0d id_valid e2", i), {31'd0, fif.id_valid}, 32'd0);
      end
      wait_drain($sformatf("vec%0d drain", i), 10);
    end

    // Three-cycle stall in steady state; skid must replay without gap or duplicate.
    do_reset();
    push_seq(32'h0, 10);
    cyc(4);
    fif.id_stall = 1'b1;
    #1;
    chk("stall imem_en", {31'd0, fif.imem_en}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk($sformatf("stall%0d id_pc", k), fif.id_pc, 32'h8);
      chk($sformatf("stall%0d id_valid", k), {31'd0, fif.id_valid}, 32'd1);
      chk($sformatf("stall%0d imem_addr", k), fif.imem_addr, 32'h10);
    end
    fif.id_stall = 1'b0;
    wait_drain("stall drain", 20);

    // Redirect and stall together with the skid full: redirect wins, stale word dropped.
    do_reset();
    push_seq(32'h0, 2);
    push_seq(32'h200, 2);
    cyc(3);
    fif.id_stall = 1'b1;
    cyc(1);
    fif.ex_jump    = 2'b10;
    fif.ex_rs_data = 32'h200;
    #1;
    chk("rs redirect", {31'd0, fif.redirect}, 32'd1);
    cyc(1);
    chk("rs id_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("rs imem_addr", fif.imem_addr, 32'h200);
    fif.id_stall = 1'b0;
    clear_ex();
    cyc(1);
    chk("rs id_valid e2", {31'd0, fif.id_valid}, 32'd0);
    wait_drain("rs drain", 10);

    // Reset pulse mid-stall with the skid full.
    do_reset();
    push_seq(32'h0, 2);
    cyc(3);
    fif.id_stall = 1'b1;
    cyc(1);
    rst = 1'b1;
    #1;
    chk("mid rst id_valid", {31'd0, fif.id_valid}, 32'd0);
    chk("mid rst imem_addr", fif.imem_addr, 32'h0);
    chk("mid rst imem_en", {31'd0, fif.imem_en}, 32'd0);
    chk("mid rst pre-drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    push_seq(32'h0, 3);
    cyc(1);
    rst          = 1'b0;
    fif.id_stall = 1'b0;
    wait_drain("mid rst drain", 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined processor: owns the PC, issues reads to the synchronous instruction memory, and delivers opcode/func/instruction/PC to the decode stage.
- Consumes the decoder's `jump` and `branch_inst` encodings, resolved in the execute stage, and redirects the PC on taken control flow.
- Holds fetched instructions across decode-stage stalls with a one-entry skid register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  instruction memory address (byte address, word aligned).
- imem_en  out  1  read enable; data for the address presented in cycle N returns on imem_rdata in cycle N+1.
- imem_rdata  in  32  instruction memory read data.
- id_stall  in  1  decode cannot accept; hold id_* outputs.
- ex_jump  in  2  decoder jump code: 00 none, 01 j/jal, 10 jr, 11 ignored.
- ex_branch_inst  in  2  decoder branch code: 00 none, 01 beq, 10 bne, 11 ignored.
- ex_alu_zero  in  1  ALU zero flag of the execute-stage instruction.
- ex_pc_plus4  in  32  PC+4 of the execute-stage instruction.
- ex_imm  in  32  sign-extended 16-bit immediate.
- ex_instr_index  in  26  j/jal target field.
- ex_rs_data  in  32  rs value, used as the jr target.
- id_valid  out  1  id_* fields hold a valid instruction.
- id_instr  out  32  fetched instruction.
- id_opcode  out  6  id_instr[31:26].
- id_func  out  6  id_instr[5:0].
- id_pc  out  32  address of id_instr.
- id_pc_plus4  out  32  id_pc + 4.
- redirect  out  1  combinational; high when execute forces a PC change this cycle.

Behaviour:
- Reset values (asynchronous):
  - pc = RESET_PC.
  - id_valid = 0; id_instr, id_pc, id_pc_plus4 = 0.
  - Skid register empty; in-flight flag = 0.
- Outputs:
  - imem_addr = pc.
  - imem_en = !id_stall && !rst.
- Redirect conditions:
  - Taken = (ex_jump==01) | (ex_jump==10) | (ex_branch_inst==01 & ex_alu_zero) | (ex_branch_inst==10 & !ex_alu_zero).
  - redirect = taken.
- Redirect targets (first match wins; all adds 32-bit modulo, wrap-around permitted):
  1. jump 01: {ex_pc_plus4[31:28], ex_instr_index, 2'b00}.
  2. jump 10: ex_rs_data, used unmodified; low bits are not masked.
  3. branch taken: ex_pc_plus4 + (ex_imm << 2).
- Jump code takes priority over branch code when both are nonzero.
- There are no delay slots. On redirect:
  - pc <= target.
  - In-flight read squashed (inflight <= 0); skid cleared.
  - id_valid <= 0.
  - First instruction at the target reaches id_valid two cycles after the redirect cycle.
- Redirect has priority over id_stall.
- Normal cycle (no redirect, no stall):
  - pc <= pc+4; inflight <= 1; inflight_pc <= pc.
  - If skid is full: id <= skid, skid <= imem_rdata (when inflight), otherwise skid empties.
  - Else: id <= imem_rdata tagged inflight_pc, id_valid <= inflight.
- Stall cycle (no redirect):
  - pc held; no new read issued (inflight <= 0).
  - id_* held.
  - If inflight and skid empty: skid <= imem_rdata with inflight_pc.
  - Skid depth of one is sufficient because only one read is ever outstanding.
- Latency: reset release to first id_valid is 2 cycles (issue, capture).
- Steady state: one instruction per cycle.
- Reset asserted mid-operation (including during a stall or redirect): state returns to reset values immediately; fetch restarts at RESET_PC.

Test Plan:
- Reset, imem word k = 32'h0C00_0000+k: imem_addr 0,4,8 on consecutive cycles; id_valid rises on the 2nd edge with id_instr=32'h0C00_0000, id_pc=0, then id_pc 4, 8 sequentially.
- id_stall held 3 cycles in steady state: id_* frozen, imem_addr constant, imem_en=0. On release, the skid instruction appears next with no gap or duplicate; the id_pc sequence stays contiguous.
- Branch: ex_branch_inst=01, ex_alu_zero=1, ex_pc_plus4=32'h40, ex_imm=32'hFFFF_FFFC: redirect=1, next imem_addr=32'h30, id_valid=0 for 2 cycles. With ex_alu_zero=0: no redirect. bne case inverted.
- Jump: ex_jump=01, ex_pc_plus4=32'h1000_0004, ex_instr_index=26'h10 -> imem_addr 32'h1000_0040. ex_jump=10, ex_rs_data=32'h200 -> imem_addr 32'h200. Jump and branch asserted together -> jump target used.
- Redirect and id_stall asserted in the same cycle: redirect wins, skid cleared, and the stale instruction never appears on id_*.
- rst pulsed mid-stall with the skid full: id_valid=0 and imem_addr=RESET_PC immediately; no stale instruction is delivered after release.
